// File: rtl/mult_div_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-subtract step per clock, HI/LO held for MFHI/MFLO.
// Define MULT_DIV_SEQ_SIGNED_EN to build signed MULT/DIV (op_in[0]); otherwise every op runs unsigned.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             stall_out,
    output logic             done_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_by_zero_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;

    logic               start_ok;
    logic               div_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef MULT_DIV_SEQ_SIGNED_EN
    logic neg_res;
    logic neg_rem;
    logic a_neg;
    logic b_neg;

    function automatic logic [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
        return -v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_wide(input logic signed [2*WIDTH-1:0] v);
        return -v;
    endfunction

    assign a_neg = op_in[0] & a_in[WIDTH-1];
    assign b_neg = op_in[0] & b_in[WIDTH-1];
    assign a_mag = a_neg ? negate(a_in) : a_in;
    assign b_mag = b_neg ? negate(b_in) : b_in;
`else
    logic unused_op_sign;

    assign unused_op_sign = op_in[0];
    assign a_mag = a_in;
    assign b_mag = b_in;
`endif

    assign start_ok  = start_in && (state != RUN);
    assign div_zero  = op_in[1] && (b_in == '0);
    assign busy_out  = (state == RUN);
    assign done_out  = (state == DONE);
    assign stall_out = busy_out | (start_in & (state != RUN));

    always_comb begin
        state_next = state;
        if (start_ok) begin
            state_next = div_zero ? DONE : RUN;
        end else begin
            case (state)
                RUN:     if (count == CW'(1)) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    // One iteration: the multiply adds the multiplicand when the multiplier LSB is set then shifts right;
    // the divide shifts the next dividend bit into the partial remainder and subtracts when no borrow results.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, opnd & {WIDTH{acc_lo[0]}}};
        div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};
        if (is_div) begin
            step_lo = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
            step_hi = div_trial[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]}
                                       : div_trial[WIDTH-1:0];
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        res_hi = step_hi;
        res_lo = step_lo;
`ifdef MULT_DIV_SEQ_SIGNED_EN
        if (is_div) begin
            if (neg_res) res_lo = negate(step_lo);
            if (neg_rem) res_hi = negate(step_hi);
        end else if (neg_res) begin
            {res_hi, res_lo} = negate_wide({step_hi, step_lo});
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            count           <= '0;
            acc_hi          <= '0;
            acc_lo          <= '0;
            opnd            <= '0;
            is_div          <= 1'b0;
            hi_out          <= '0;
            lo_out          <= '0;
            div_by_zero_out <= 1'b0;
`ifdef MULT_DIV_SEQ_SIGNED_EN
            neg_res         <= 1'b0;
            neg_rem         <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (start_ok) begin
                count           <= CW'(WIDTH);
                acc_hi          <= '0;
                acc_lo          <= op_in[1] ? a_mag : b_mag;
                opnd            <= op_in[1] ? b_mag : a_mag;
                is_div          <= op_in[1];
                div_by_zero_out <= div_zero;
`ifdef MULT_DIV_SEQ_SIGNED_EN
                neg_res         <= a_neg ^ b_neg;
                neg_rem         <= a_neg;
`endif
                if (div_zero) begin
                    hi_out <= a_in;
                    lo_out <= '1;
                end
            end else if (state == RUN) begin
                count  <= count - CW'(1);
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                if (count == CW'(1)) begin
                    hi_out <= res_hi;
                    lo_out <= res_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Randomized self-checking bench for mult_div_seq against a plain-arithmetic HI/LO model.
// Follows MULT_DIV_SEQ_SIGNED_EN the same way as the design.
module tb_mult_div_seq;

    localparam int WIDTH = 32;
`ifdef MULT_DIV_SEQ_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start_in = 1'b0;
    logic [1:0]        op_in = 2'b00;
    logic [WIDTH-1:0]  a_in = '0;
    logic [WIDTH-1:0]  b_in = '0;
    logic              busy_out;
    logic              stall_out;
    logic              done_out;
    logic [WIDTH-1:0]  hi_out;
    logic [WIDTH-1:0]  lo_out;
    logic              div_by_zero_out;

    int                n_checks = 0;
    int                n_fail = 0;
    logic [WIDTH-1:0]  exp_hi;
    logic [WIDTH-1:0]  exp_lo;
    logic              exp_dz;
    int                exp_lat;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              seen_done;

    mult_div_seq #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_in        (start_in),
        .op_in           (op_in),
        .a_in            (a_in),
        .b_in            (b_in),
        .busy_out        (busy_out),
        .stall_out       (stall_out),
        .done_out        (done_out),
        .hi_out          (hi_out),
        .lo_out          (lo_out),
        .div_by_zero_out (div_by_zero_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Architectural result of one instruction, straight from integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        bit          sgn;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sgn = SIGNED_EN && op[0];
        sa  = sgn ? longint'($signed(a)) : longint'({32'h0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'h0, b});
        dz  = 1'b0;
        if (!op[1]) begin
            p  = sgn ? 64'(sa * sb) : ({32'h0, a} * {32'h0, b});
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'h0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a falling edge; returns one falling edge after the request was sampled.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start_in = 1'b1;
        op_in    = op;
        a_in     = a;
        b_in     = b;
        model(op, a, b, exp_hi, exp_lo, exp_dz);
        exp_lat = (op[1] && b == 32'h0) ? 1 : WIDTH + 1;
        #1 check("stall_req", stall_out, 1);
        @(negedge clk);
        start_in = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
        check("start_busy", busy_out, exp_lat > 1);
        check("start_dz", div_by_zero_out, exp_dz);
    endtask

    task automatic finish_op(input string tag, input int inject);
        int cyc = 1;
        int busy_cnt = 0;
        while (!done_out && cyc <= exp_lat + 4) begin
            if (busy_out) busy_cnt++;
            if (cyc == inject) begin
                start_in = 1'b1;
                op_in    = 2'b10;
                a_in     = 32'd100;
                b_in     = 32'd0;
                #1 check({tag, "_stall_busy"}, stall_out, 1);
            end
            @(negedge clk);
            start_in = 1'b0;
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_done"}, done_out, 1);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
        check({tag, "_hi"}, hi_out, exp_hi);
        check({tag, "_lo"}, lo_out, exp_lo);
        check({tag, "_dz"}, div_by_zero_out, exp_dz);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done_out, 0);
        check({tag, "_idle_busy"}, busy_out, 0);
        check({tag, "_hold_hi"}, hi_out, exp_hi);
        check({tag, "_hold_lo"}, lo_out, exp_lo);
        check({tag, "_hold_dz"}, div_by_zero_out, exp_dz);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_stall", stall_out, 0);
        check("rst_dz", div_by_zero_out, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        reset = 1'b1;
        @(negedge clk);

        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("t1", 0);
        check("t1_hi_const", hi_out, 32'hFFFF_FFFE);
        check("t1_lo_const", lo_out, 32'h0000_0001);
        idle_check("t1");

        start_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005);
        finish_op("t2", 0);
        check("t2_hi_const", hi_out, SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0004);
        check("t2_lo_const", lo_out, 32'hFFFF_FFF1);
        idle_check("t2");

        start_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        finish_op("t3a", 0);
        check("t3a_lo_const", lo_out, SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC);
        check("t3a_hi_const", hi_out, SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001);
        idle_check("t3a");

        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("t3b", 0);
        check("t3b_lo_const", lo_out, SIGNED_EN ? 32'h8000_0000 : 32'h0000_0000);
        check("t3b_hi_const", hi_out, SIGNED_EN ? 32'h0000_0000 : 32'h8000_0000);
        idle_check("t3b");

        start_op(2'b10, 32'h0000_0007, 32'h0000_0000);
        finish_op("t4", 0);
        check("t4_hi_const", hi_out, 32'h0000_0007);
        check("t4_lo_const", lo_out, 32'hFFFF_FFFF);
        check("t4_dz_const", div_by_zero_out, 1);
        idle_check("t4");

        start_op(2'b00, 32'd3, 32'd4);
        finish_op("t5", 5);
        check("t5_hi_const", hi_out, 32'h0);
        check("t5_lo_const", lo_out, 32'hC);
        start_op(2'b00, 32'd5, 32'd6);
        finish_op("t5b2b", 0);
        idle_check("t5b2b");

        start_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("t6_busy", busy_out, 0);
        check("t6_done", done_out, 0);
        check("t6_stall", stall_out, 0);
        check("t6_dz", div_by_zero_out, 0);
        check("t6_hi", hi_out, 0);
        check("t6_lo", lo_out, 0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_out) seen_done = 1'b1;
        end
        check("t6_no_done", seen_done, 0);
        start_op(2'b00, 32'd2, 32'd2);
        finish_op("t6b", 0);
        check("t6b_lo_const", lo_out, 32'd4);
        idle_check("t6b");

        for (int i = 0; i < 60; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = pick();
            r_b  = pick();
            start_op(r_op, r_a, r_b);
            finish_op("rnd", 0);
            if ($urandom_range(0, 2) != 0) idle_check("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
